// File: rtl/iir1_mc_filter_pkg.sv
// Shared definitions for the multi-channel first-order IIR filter.
// Holds the default parameter values, the channel-index width helper and
// the default signed sample type.
package iir1_mc_filter_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int CHANNELS_DEF   = 4;
    localparam int LEAK_SHIFT_DEF = 4;

    typedef logic signed [DATA_W_DEF-1:0] sample_t;

    // Channel index width; a single-channel build still gets a 1-bit index.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iir1_mc_filter_if.sv
// Stream bundle for iir1_mc_filter: input sample channel (in_*, mode) and
// result channel (out_*), both valid/ready handshaked.
//   master : sample producer / result consumer (testbench or upstream logic)
//   slave  : the filter
interface iir1_mc_filter_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     mode;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     out_err;

    modport master (
        output in_valid, in_ch, in_data, mode, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_ch, in_data, mode, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_sat, out_err
    );
endinterface

// File: rtl/iir1_mc_filter_sat_clip.sv
// sat_clip: clamp a signed IN_W-bit value into the signed OUT_W-bit range.
//   din  : signed input, IN_W bits
//   dout : clamped result, OUT_W bits
//   sat  : high when din was outside the OUT_W range
module sat_clip #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    // The value fits when every bit from the OUT_W sign bit upward agrees.
    logic [IN_W-OUT_W:0] top;

    assign top  = din[IN_W-1:OUT_W-1];
    assign sat  = !((&top) || !(|top));
    assign dout = !sat         ? din[OUT_W-1:0] :
                  din[IN_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}} :
                                 {1'b0, {(OUT_W-1){1'b1}}};
endmodule

// File: rtl/iir1_mc_filter.sv
// iir1_mc_filter: time-multiplexed first-order IIR, one state pair per channel.
//   Y[n] = X[n] + X[n-1] + Y[n-1] - (mode ? Y[n-1] >>> LEAK_SHIFT : 0), saturated.
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   clear      : synchronous flush of all channel state and the output register
//   bus        : sample/result streams (slave side), see iir1_mc_filter_if
module iir1_mc_filter
    import iir1_mc_filter_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int CHANNELS   = CHANNELS_DEF,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    iir1_mc_filter_if.slave bus
);
    localparam int CH_W = ch_w(CHANNELS);
    localparam int SW   = DATA_W + 2;   // x + x1 + y1 needs two guard bits

    logic signed [DATA_W-1:0] x1 [CHANNELS];
    logic signed [DATA_W-1:0] y1 [CHANNELS];

    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;
    logic                     out_err;

    logic                     accept;
    logic                     ch_ok;
    logic [CH_W-1:0]          ch_idx;
    logic signed [SW-1:0]     xe, x1e, y1e, leak, s;
    logic signed [DATA_W-1:0] sat_val;
    logic                     sat_flag;

    // One-entry output register: a new sample may enter whenever the held
    // result is absent or is being consumed on this same edge.
    assign bus.in_ready  = !out_valid || bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ch    = out_ch;
    assign bus.out_data  = out_data;
    assign bus.out_sat   = out_sat;
    assign bus.out_err   = out_err;

    assign accept = bus.in_valid && bus.in_ready && !clear;
    assign ch_ok  = int'(bus.in_ch) < CHANNELS;
    // Out-of-range channels read a valid entry; the result is discarded anyway.
    assign ch_idx = ch_ok ? bus.in_ch : '0;

    assign xe   = {{2{bus.in_data[DATA_W-1]}}, bus.in_data};
    assign x1e  = {{2{x1[ch_idx][DATA_W-1]}}, x1[ch_idx]};
    assign y1e  = {{2{y1[ch_idx][DATA_W-1]}}, y1[ch_idx]};
    assign leak = y1e >>> LEAK_SHIFT;
    assign s    = xe + x1e + y1e - (bus.mode ? leak : '0);

    sat_clip #(.IN_W(SW), .OUT_W(DATA_W)) u_sat (
        .din  (s),
        .dout (sat_val),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x1[c] <= '0;
                y1[c] <= '0;
            end
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) begin
                x1[c] <= '0;
                y1[c] <= '0;
            end
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= bus.in_ch;
            if (ch_ok) begin
                out_data     <= sat_val;
                out_sat      <= sat_flag;
                out_err      <= 1'b0;
                x1[ch_idx]   <= bus.in_data;
                y1[ch_idx]   <= sat_val;
            end else begin
                out_data <= '0;
                out_sat  <= 1'b0;
                out_err  <= 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iir1_mc_filter.sv
// Directed bench for iir1_mc_filter (DATA_W=16, CHANNELS=3, LEAK_SHIFT=4).
// CHANNELS=3 leaves index 3 reachable on a 2-bit in_ch for the error path.
module tb_iir1_mc_filter;
    import iir1_mc_filter_pkg::*;

    localparam int DW = 16;
    localparam int NCH = 3;
    localparam int CW = 2;
    localparam int NV = 21;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;

    iir1_mc_filter_if #(.DATA_W(DW), .CH_W(CW)) bus ();

    iir1_mc_filter #(.DATA_W(DW), .CHANNELS(NCH), .LEAK_SHIFT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          clr;
        logic [1:0]  ch;
        bit          mode;
        int          x;
        int          y;
        bit          sat;
        bit          err;
    } vec_t;

    vec_t vecs [NV];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] ch, input bit m, input int x);
        bus.in_valid = v;
        bus.in_ch    = ch;
        bus.mode     = m;
        bus.in_data  = DW'(x);
    endtask

    initial begin
        vecs = '{
            '{0, 2'd0, 0,      1,      1, 0, 0},
            '{0, 2'd0, 0,      2,      4, 0, 0},
            '{0, 2'd0, 0,      3,      9, 0, 0},
            '{0, 2'd1, 0,  20000,  20000, 0, 0},
            '{0, 2'd1, 0,  20000,  32767, 1, 0},
            '{0, 2'd1, 0, -32768,  19999, 0, 0},
            '{0, 2'd2, 0, -20000, -20000, 0, 0},
            '{0, 2'd2, 0, -20000, -32768, 1, 0},
            '{1, 2'd0, 0,     99,      0, 0, 0},
            '{0, 2'd0, 1,     16,     16, 0, 0},
            '{0, 2'd0, 1,     16,     47, 0, 0},
            '{1, 2'd1, 0,     55,      0, 0, 0},
            '{0, 2'd0, 0,      1,      1, 0, 0},
            '{0, 2'd1, 0,      5,      5, 0, 0},
            '{0, 2'd0, 0,      1,      3, 0, 0},
            '{0, 2'd2, 1,    -16,    -16, 0, 0},
            '{0, 2'd2, 1,    -16,    -47, 0, 0},
            '{0, 2'd3, 0,   1234,      0, 0, 1},
            '{0, 2'd0, 0,      1,      5, 0, 0},
            '{1, 2'd0, 0,      0,      0, 0, 0},
            '{0, 2'd0, 0,      7,      7, 0, 0}
        };

        drive(0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_err", int'(bus.out_err), 0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            clear = vecs[i].clr;
            drive(1, vecs[i].ch, vecs[i].mode, vecs[i].x);
            @(posedge clk);
            #1;
            if (vecs[i].clr) begin
                chk($sformatf("v%0d_clr_valid", i), int'(bus.out_valid), 0);
            end else begin
                chk($sformatf("v%0d_valid", i), int'(bus.out_valid), 1);
                chk($sformatf("v%0d_ch", i), int'(bus.out_ch), int'(vecs[i].ch));
                chk($sformatf("v%0d_data", i), int'(bus.out_data), vecs[i].y);
                chk($sformatf("v%0d_sat", i), int'(bus.out_sat), int'(vecs[i].sat));
                chk($sformatf("v%0d_err", i), int'(bus.out_err), int'(vecs[i].err));
            end
            clear = 1'b0;
        end

        // Back-pressure: the held result (ch0, Y=7) must stay put while a
        // waiting sample is refused.
        drive(1, 0, 0, 100);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_in_ready_pre", int'(bus.in_ready), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_in_ready", k), int'(bus.in_ready), 0);
            chk($sformatf("bp%0d_valid", k), int'(bus.out_valid), 1);
            chk($sformatf("bp%0d_data", k), int'(bus.out_data), 7);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_rel", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        // 100 + x1(7) + y1(7): state was untouched during the stall
        chk("bp_next_data", int'(bus.out_data), 114);
        chk("bp_next_valid", int'(bus.out_valid), 1);
        drive(0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("drain_valid", int'(bus.out_valid), 0);

        // Reset mid-stream drops a pending result and wipes channel state.
        bus.out_ready = 1'b0;
        drive(1, 1, 0, 9);
        @(posedge clk);
        #1;
        chk("pend_valid", int'(bus.out_valid), 1);
        drive(0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", int'(bus.out_valid), 0);
        chk("midrst_data", int'(bus.out_data), 0);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        drive(1, 0, 0, 3);
        @(posedge clk);
        #1;
        chk("post_rst_data", int'(bus.out_data), 3);
        drive(1, 1, 0, 4);
        @(posedge clk);
        #1;
        chk("post_rst_ch1", int'(bus.out_data), 4);
        drive(0, 0, 0, 0);
        @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/iir1_mc_filter.md
IIR1_MC_FILTER -- requirements
Module: iir1_mc_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample/result width (signed two's complement).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent time-multiplexed channels (>=1).
REQ-003 SHALL have parameter LEAK_SHIFT, default 4, leak coefficient 2^-LEAK_SHIFT used in leaky mode (1..DATA_W-1).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clear  input  1  synchronous flush of all channel state.
REQ-007 SHALL have port mode  input  1  0 = integrate, 1 = leaky; sampled at input accept.
REQ-008 SHALL have port in_valid  input  1  input sample present.
REQ-009 SHALL have port in_ready  output  1  block can accept a sample.
REQ-010 SHALL have port in_ch  input  CH_W  channel index, CH_W = max(1,clog2(CHANNELS)).
REQ-011 SHALL have port in_data  input  DATA_W  signed sample X[n].
REQ-012 SHALL have port out_valid  output  1  result present.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_ch  output  CH_W  channel of result.
REQ-015 SHALL have port out_data  output  DATA_W  signed result Y[n].
REQ-016 SHALL have port out_sat  output  1  result was clipped.
REQ-017 SHALL have port out_err  output  1  in_ch was >= CHANNELS.

Function
REQ-018 Accept SHALL occur on a clk edge with in_valid && in_ready && !clear.
REQ-019 in_ready SHALL equal !out_valid || out_ready (one-entry output register, combinational back-pressure).
REQ-020 Per channel c, SHALL keep state x1[c], y1[c] (DATA_W each).
REQ-021 On accept, SHALL compute s = x + x1[c] + y1[c] - (mode ? (y1[c] >>> LEAK_SHIFT) : 0) at DATA_W+2 bits signed, arithmetic shift.
REQ-022 Result SHALL saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat = 1 when clipped.
REQ-023 On accept, SHALL update x1[c] <= x and y1[c] <= saturated result in the same edge.
REQ-024 Result SHALL appear on out_* with out_valid = 1 on the edge of accept (latency 1 cycle).
REQ-025 out_valid && !out_ready SHALL hold out_ch/out_data/out_sat/out_err stable.
REQ-026 out_valid SHALL clear on an edge with out_ready and no new accept; back-to-back accepts SHALL give one result per cycle.
REQ-027 in_ch >= CHANNELS SHALL be accepted, produce out_data = 0, out_err = 1, no state change.
REQ-028 clear SHALL zero all x1/y1 and out_valid at the next edge; clear with in_valid SHALL discard the sample.
REQ-029 Different channels SHALL be independent; interleaved order SHALL not affect per-channel results.

Reset
REQ-030 reset SHALL asynchronously zero all x1[c], y1[c], out_valid, out_data, out_ch, out_sat, out_err.
REQ-031 First accepted sample per channel after reset/clear SHALL give Y = X (saturated).
REQ-032 Reset mid-stream SHALL drop any pending output; in_ready = 1 after reset deasserts.

Structure
REQ-033 Shared package SHALL hold DATA_W/CHANNELS/LEAK_SHIFT defaults, CH_W function, and sample_t signed typedef.
REQ-034 Saturation SHALL be a sub-module sat_clip (parameter IN_W, OUT_W; outputs value and sat flag).
REQ-035 Channel state SHALL be register arrays indexed by in_ch; no RAM inference required.

Verification
REQ-036 Reset, ch0 mode0, X = 1,2,3 -> Y = 1, 4, 9.
REQ-037 DATA_W=16, ch1 mode0, X = 20000, 20000 -> Y = 20000, 32767 with out_sat = 1 on second.
REQ-038 mode1 LEAK_SHIFT=4, ch0 X = 16, 16 -> Y = 16, 47 (16+16+16-1).
REQ-039 Interleave ch0 X=1, ch1 X=5, ch0 X=1, out_ready=1 -> Y = 1, 5, 3.
REQ-040 out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, output stable, no state change; release -> results in order.
REQ-041 in_ch = CHANNELS -> out_err = 1, out_data = 0; clear asserted -> next ch0 X = 7 gives Y = 7.
